// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between MEM and the data-memory write port, with byte-merge forwarding to loads.
// Optional macro STB_TRACE_EN prints one trace line per drained store.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_wd,
  input  logic [3:0]        st_be,
  input  logic [31:0]       st_pc,
  input  logic              dm_ready,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wd,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       ld_data,
  output logic              ld_hit,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      wd_q   [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;
  logic             unused_low_bits;

  assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // No pop bypass: a full buffer refuses stores even in a draining cycle.
  assign st_ready = (count_q != FULL_CNT);
  assign push     = st_valid & st_ready & (st_be != 4'h0);
  // Gating with reset keeps a reset cycle from committing a drain write.
  assign dm_we    = (count_q != '0) & ~reset;
  assign pop      = dm_we & dm_ready;
  assign count    = count_q;

  assign dm_addr = {addr_q[rptr], 2'b00};
  assign dm_wd   = wd_q[rptr];
  assign dm_be   = be_q[rptr];
  assign dm_pc   = pc_q[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) be_q[i] <= 4'h0;
    end else begin
      if (push) begin
        wptr       <= wptr + 1'b1;
        be_q[wptr] <= st_be;
      end
      if (pop) rptr <= rptr + 1'b1;
      count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Payload fields carry no reset; validity comes from rptr/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr] <= st_addr[31:2];
      wd_q[wptr]   <= st_wd;
      pc_q[wptr]   <= st_pc;
    end
  end

  // Oldest-to-youngest walk so the youngest matching writer owns each lane.
  always_comb begin
    logic [PTR_W-1:0] idx;
    ld_data = dm_rdata;
    ld_hit  = 1'b0;
    idx     = rptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_q[idx] == ld_addr[31:2])) begin
        if (be_q[idx] != 4'h0) ld_hit = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (be_q[idx][b]) ld_data[8*b +: 8] = wd_q[idx][8*b +: 8];
        end
      end
    end
  end

`ifdef STB_TRACE_EN
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (pop) $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, dm_wd & lane_mask(dm_be));
  end
`endif

endmodule
